// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel front end: default geometry and 3x3 window slot indices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sobel_pkg;

  localparam int DEF_DW    = 12;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  // Window geometry: slot k = r*WIN_N + c, r=0 oldest row, c=0 oldest column.
  localparam int WIN_N   = 3;
  localparam int NSLOT   = WIN_N * WIN_N;
  localparam int SLOT_TR = 2;  // row y-2, column x
  localparam int SLOT_MR = 5;  // row y-1, column x
  localparam int SLOT_BR = 8;  // row y,   column x (the accepted pixel)

  function automatic int slot(input int r, input int c);
    return r * WIN_N + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage: single write port, registered read port, no reset on contents.
// Latency: read data appears the cycle after i_re with i_raddr.
// Backpressure: none; read output holds while i_re is low.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 12,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port: stores one pixel per enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port: a read in the same cycle as a write to the same address returns old data.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_window.sv
// Builds a 3x3 pixel window from a raster stream using two line buffers.
// Latency: window for pixel (x,y) is flagged 2 cycles after that pixel is accepted.
// Backpressure: none; i_valid gaps stall the window and o_data holds.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [DW-1:0]    i_data,
  input  logic             i_valid,
  input  logic             i_sof,
  output logic [9*DW-1:0]  o_data,
  output logic             o_valid
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Coordinates of the pixel on the input this cycle; start of frame forces (0,0).
  logic          w_sof;
  logic [CW-1:0] w_x;
  logic [RW-1:0] w_y;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_win_ok;

  assign w_sof      = i_valid & i_sof;
  assign w_x        = w_sof ? '0 : r_col;
  assign w_y        = w_sof ? '0 : r_row;
  assign w_last_col = (w_x == CW'(IMG_W - 1));
  assign w_last_row = (w_y == RW'(IMG_H - 1));
  assign w_win_ok   = (int'(w_x) >= 2) && (int'(w_y) >= 2);

  // Raster position tracking: column wraps into the row, row wraps at end of frame.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : w_y + RW'(1);
      end else begin
        r_col <= w_x + CW'(1);
        r_row <= w_y;
      end
    end
  end

  // Stage 1 holds the accepted pixel while its column is read out of both line buffers.
  logic          r_s1_vld;
  logic [DW-1:0] r_s1_pix;
  logic [CW-1:0] r_s1_col;
  logic          r_s1_ok;

  // Capture accepted pixel, its column and whether its window is complete.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_s1_vld <= 1'b0;
      r_s1_pix <= '0;
      r_s1_col <= '0;
      r_s1_ok  <= 1'b0;
    end else begin
      r_s1_vld <= i_valid;
      if (i_valid) begin
        r_s1_pix <= i_data;
        r_s1_col <= w_x;
        r_s1_ok  <= w_win_ok;
      end
    end
  end

  // Row y-1 buffer takes the new pixel; row y-2 buffer takes the row y-1 value it displaces.
  logic [DW-1:0] w_y1;
  logic [DW-1:0] w_y2;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DW), .AW(CW)) u_lb_y1 (
    .i_clk   (i_clk),
    .i_we    (r_s1_vld),
    .i_waddr (r_s1_col),
    .i_wdata (r_s1_pix),
    .i_re    (i_valid),
    .i_raddr (w_x),
    .o_rdata (w_y1)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DW), .AW(CW)) u_lb_y2 (
    .i_clk   (i_clk),
    .i_we    (r_s1_vld),
    .i_waddr (r_s1_col),
    .i_wdata (w_y1),
    .i_re    (i_valid),
    .i_raddr (w_x),
    .o_rdata (w_y2)
  );

  logic [NSLOT-1:0][DW-1:0] r_win;
  logic                     r_vld;

  // Shift the window left one column per pixel and load the new column {y-2, y-1, y}.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_win <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= r_s1_vld & r_s1_ok;
      if (r_s1_vld) begin
        for (int r = 0; r < WIN_N; r++) begin
          for (int c = 0; c < WIN_N - 1; c++) begin
            r_win[slot(r, c)] <= r_win[slot(r, c + 1)];
          end
        end
        r_win[SLOT_TR] <= w_y2;
        r_win[SLOT_MR] <= w_y1;
        r_win[SLOT_BR] <= r_s1_pix;
      end
    end
  end

  assign o_data  = r_win;
  assign o_valid = r_vld;

endmodule

// File: tb/tb_sobel_window.sv
module tb_sobel_window;

  localparam int DW = 12;
  localparam int W  = 8;
  localparam int H  = 4;

  logic            i_clk   = 1'b0;
  logic            i_rstn  = 1'b0;
  logic [DW-1:0]   i_data  = '0;
  logic            i_valid = 1'b0;
  logic            i_sof   = 1'b0;
  logic [9*DW-1:0] o_data;
  logic            o_valid;

  always #5 i_clk = ~i_clk;

  sobel_window #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_sof   (i_sof),
    .o_data  (o_data),
    .o_valid (o_valid)
  );

  int total = 0;
  int bad   = 0;

  // Reference image: last pixel value seen at each (row, column) of the frame.
  logic [DW-1:0]   img [0:H-1][0:W-1];
  int              mx = 0;
  int              my = 0;
  logic            pend_v = 1'b0;
  logic [9*DW-1:0] pend_d = '0;
  logic            exp_v;
  logic [9*DW-1:0] exp_d;
  logic            chk_d;
  int              nvalid = 0;
  int              nconsec = 0;
  logic            prev_ov = 1'b0;

  // One clock cycle: drive inputs, advance the reference at the edge, compare just after it.
  task automatic cyc(input logic v, input logic sof, input logic [DW-1:0] d, input logic rst);
    int x;
    int y;
    i_valid = v;
    i_sof   = sof;
    i_data  = d;
    i_rstn  = ~rst;
    @(posedge i_clk);
    if (rst) begin
      exp_v  = 1'b0;
      exp_d  = '0;
      chk_d  = 1'b1;
      pend_v = 1'b0;
      mx     = 0;
      my     = 0;
    end else begin
      exp_v  = pend_v;
      exp_d  = pend_d;
      chk_d  = pend_v;
      pend_v = 1'b0;
      if (v) begin
        x = sof ? 0 : mx;
        y = sof ? 0 : my;
        img[y][x] = d;
        if (x >= 2 && y >= 2) begin
          pend_v = 1'b1;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              pend_d[(r*3+c)*DW +: DW] = img[y-2+r][x-2+c];
        end
        mx = (x + 1) % W;
        my = (x == W - 1) ? (y + 1) % H : y;
      end
    end
    #1;
    total++;
    assert (o_valid === exp_v) else begin
      bad++;
      $error("FAIL o_valid got=%b exp=%b t=%0t", o_valid, exp_v, $time);
    end
    if (chk_d) begin
      total++;
      assert (o_data === exp_d) else begin
        bad++;
        $error("FAIL o_data got=%h exp=%h t=%0t", o_data, exp_d, $time);
      end
    end
    if (o_valid === 1'b1) begin
      nvalid++;
      if (prev_ov) nconsec++;
    end
    prev_ov = (o_valid === 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Full frame. gap: 0 none, 1 one idle after each pixel, 2 random 0..2 idles (with stray i_sof).
  task automatic frame(input int gap, input bit rnd, input bit sof_first);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        logic [DW-1:0] d;
        d = rnd ? DW'($urandom) : DW'(y * 16 + x);
        if (rnd && x == W - 1 && y == H - 1) d = 12'hFFF;
        cyc(1'b1, 1'(sof_first && x == 0 && y == 0), d, 1'b0);
        if (gap == 1) idle(1);
        else if (gap == 2)
          repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
      end
    end
  endtask

  // Partial stream of n random pixels, optionally opening with start of frame.
  task automatic stream(input int n, input bit sof_first);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'(sof_first && i == 0), DW'($urandom), 1'b0);
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    total++;
    assert (got == want) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  initial begin
    // Reset with i_valid high: outputs must be zero and pixels ignored.
    repeat (3) cyc(1'b1, 1'b1, DW'($urandom), 1'b1);

    // Ramp frame, continuous: 12 windows.
    nvalid = 0;
    frame(0, 1'b0, 1'b1);
    idle(3);
    check_count("pulses_cont", nvalid, 12);

    // Same frame with alternating gaps: same windows, never back-to-back.
    nvalid = 0; nconsec = 0;
    frame(1, 1'b0, 1'b1);
    idle(3);
    check_count("pulses_gap", nvalid, 12);
    check_count("consec_gap", nconsec, 0);

    // Two random frames back-to-back, second one entered by counter wrap; 0xFFF at (7,3).
    nvalid = 0;
    frame(0, 1'b1, 1'b1);
    frame(0, 1'b1, 1'b0);
    idle(3);
    check_count("pulses_2frames", nvalid, 24);

    // Random gaps with stray unqualified i_sof.
    nvalid = 0;
    frame(2, 1'b1, 1'b1);
    idle(3);
    check_count("pulses_rndgap", nvalid, 12);

    // Start of frame asserted at counter position (5,1).
    nvalid = 0;
    stream(W + 5, 1'b1);
    frame(0, 1'b1, 1'b1);
    idle(3);
    check_count("pulses_midsof", nvalid, 12);

    // One-cycle reset during row 3, then a frame without i_sof.
    stream(3 * W + 3, 1'b1);
    cyc(1'b1, 1'b0, DW'($urandom), 1'b1);
    nvalid = 0;
    frame(0, 1'b1, 1'b0);
    idle(3);
    check_count("pulses_after_rst", nvalid, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 Parameter DW, default 12, pixel data width in bits.
REQ-002 Parameter IMG_W, default 640, pixels per line.
REQ-003 Parameter IMG_H, default 480, lines per frame.
REQ-004 i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 i_rstn  input  1  reset, synchronous, active-low.
REQ-006 i_data  input  DW  incoming pixel, raster order.
REQ-007 i_valid  input  1  i_data is accepted on every cycle this is high; no backpressure.
REQ-008 i_sof  input  1  start of frame; qualified by i_valid; marks the pixel at column 0, row 0.
REQ-009 o_data  output  9*DW  3x3 window; slot k = r*3+c at bits [k*DW +: DW].
REQ-010 o_valid  output  1  o_data holds a complete window, single-cycle qualifier.

Function
REQ-011 Slot mapping SHALL be: r=0 is row y-2, r=2 is row y (current); c=0 is column x-2, c=2 is column x (current); slot 8 is the accepted pixel (x,y).
REQ-012 Column counter SHALL increment on each accepted pixel, wrap IMG_W-1 to 0, and increment the row counter on wrap.
REQ-013 Row counter SHALL wrap IMG_H-1 to 0 when the column wraps at the last line.
REQ-014 Accepted pixel with i_sof=1 SHALL be taken as (0,0) regardless of counter state; its successor is (1,0).
REQ-015 i_sof with i_valid=0 SHALL be ignored.
REQ-016 Two line buffers of IMG_W x DW SHALL hold rows y-1 and y-2, addressed by column.
REQ-017 Line buffer read SHALL be synchronous; write of column x SHALL occur one cycle after the read of column x.
REQ-018 Per accepted pixel, the window SHALL shift left one column and load {row y-2, row y-1, row y} at column x.
REQ-019 The row y-1 buffer SHALL take the new pixel; the row y-2 buffer SHALL take the old row y-1 value.
REQ-020 o_valid SHALL be high exactly 2 cycles after the cycle in which pixel (x,y) is accepted, iff x>=2 and y>=2.
REQ-021 Windows for x<2 or y<2 SHALL NOT assert o_valid; o_data content there is don't-care.
REQ-022 i_valid gaps of any length SHALL stall the window without loss or duplication; o_valid SHALL be low for each gap cycle.
REQ-023 Back-to-back accepted pixels SHALL produce back-to-back o_valid (throughput 1 pixel/cycle).
REQ-024 o_data SHALL hold its last value while o_valid is low.
REQ-025 Line buffer contents SHALL NOT be cleared on i_sof; stale data is masked by REQ-021.

Reset
REQ-026 With i_rstn low at a rising edge: o_valid=0, o_data=0, column=0, row=0, all internal valid pipeline bits=0.
REQ-027 Line buffer RAM contents SHALL NOT be reset.
REQ-028 Reset mid-frame SHALL make the next accepted pixel (0,0), with or without i_sof.
REQ-029 i_valid during reset SHALL be ignored; no o_valid is produced for pixels accepted before release.

Structure
REQ-030 DW, IMG_W, IMG_H defaults and the slot-index constants SHALL live in the shared package sobel_pkg, used also by the convolution stage.
REQ-031 One sub-module, line_buffer (depth IMG_W, width DW, one write port, one registered read port), SHALL be instantiated twice.
REQ-032 o_data/o_valid SHALL connect directly to the convolution stage i_data/i_valid with no glue logic.

Verification
REQ-033 IMG_W=8, IMG_H=4, pixel=row*16+col, continuous i_valid, i_sof on first -> first o_valid 2 cycles after (2,2); o_data slots 0..8 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
REQ-034 Same frame -> exactly 12 o_valid pulses; none for columns 0-1 or rows 0-1.
REQ-035 Same frame with i_valid toggling 1,0,1,0 -> identical window sequence; o_valid never on consecutive cycles.
REQ-036 i_sof asserted at pixel (5,1) mid-frame -> that pixel treated as (0,0); no o_valid until new (2,2).
REQ-037 i_rstn low 1 cycle during row 3 -> o_valid and o_data are 0 the next cycle; next accepted pixel treated as (0,0); no o_valid until new (2,2).
REQ-038 Stream 2 frames back-to-back, pixel=0xFFF at (7,3) -> window at (2,0) of frame 2 is not flagged; row wrap after (7,3) is correct.
